// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencing controller:
// FSM state encoding, coin values, payout denominations and coin-decode helpers.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    PAYOUT  = 2'd2,
    FAULT   = 2'd3
  } vend_state_e;

  localparam logic [2:0] VAL1 = 3'd1;
  localparam logic [2:0] VAL2 = 3'd2;
  localparam logic [2:0] VAL5 = 3'd5;

  localparam logic [2:0] PAY_BIG   = 3'd2;
  localparam logic [2:0] PAY_SMALL = 3'd1;

  // Value of the single coin that wins arbitration (coin5 > coin2 > coin1).
  function automatic logic [2:0] coin_value(input logic c5, input logic c2, input logic c1);
    logic [2:0] v;
    if (c5) begin
      v = VAL5;
    end else if (c2) begin
      v = VAL2;
    end else if (c1) begin
      v = VAL1;
    end else begin
      v = 3'd0;
    end
    return v;
  endfunction

  function automatic logic coin_multi(input logic c5, input logic c2, input logic c1);
    return (c5 & (c2 | c1)) | (c2 & c1);
  endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Request/acknowledge wait counter for the hopper handshakes; flags expiry after
// ACK_TIMEOUT request-high cycles without ack. Exists only with VEND_CTRL_TIMEOUT_EN.
`ifdef VEND_CTRL_TIMEOUT_EN
module ack_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             waiting_s;

  assign waiting_s = req & ~ack;
  assign expired   = waiting_s & (cnt_r == LAST);

  // Wait counter: any cycle without an outstanding unanswered request restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (waiting_s && !expired) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

endmodule
`endif

// File: rtl/vend_ctrl.sv
// Vending sequencer: coin credit accumulation, product vend handshake and greedy
// change payout. Optional hopper timeout/FAULT state under VEND_CTRL_TIMEOUT_EN.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE       = 3,
  parameter int unsigned CREDIT_W    = 4,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin1,
  input  logic                coin2,
  input  logic                coin5,
  input  logic                cancel,
  output logic                vend_req,
  input  logic                vend_ack,
  output logic                pay1_req,
  output logic                pay2_req,
  input  logic                pay_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_rej,
  output logic                busy,
  output logic                fault
);

  localparam int unsigned CW1        = CREDIT_W + 1;
  localparam int unsigned MAX_CREDIT = (1 << CREDIT_W) - 1;
  localparam logic [CREDIT_W:0]   MAX_W   = CW1'(MAX_CREDIT);
  localparam logic [CREDIT_W:0]   PRICE_W = CW1'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] PAY2_C  = CREDIT_W'(PAY_BIG);
  localparam logic [CREDIT_W-1:0] PAY1_C  = CREDIT_W'(PAY_SMALL);

  if (PRICE < 1 || PRICE > MAX_CREDIT || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("vend_ctrl: PRICE or ACK_TIMEOUT out of range");
  end

  vend_state_e         state_r, state_s;
  logic [CREDIT_W-1:0] credit_r, credit_s;
  logic                vend_req_r, vend_req_s;
  logic                pay1_req_r, pay1_req_s;
  logic                pay2_req_r, pay2_req_s;
  logic                coin_rej_r, coin_rej_s;
  logic                busy_r, busy_s;
  logic                coin_any_s;
  logic                pay_acked_s;
  logic [CREDIT_W:0]   sum_s;

  assign coin_any_s = coin1 | coin2 | coin5;
  assign sum_s      = {1'b0, credit_r} + CW1'(coin_value(coin5, coin2, coin1));

`ifdef VEND_CTRL_TIMEOUT_EN
  logic fault_r, fault_s;
  logic expired_s;

  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clk    (clk),
    .rst    (rst),
    .req    (vend_req_r | pay1_req_r | pay2_req_r),
    .ack    ((vend_req_r & vend_ack) | ((pay1_req_r | pay2_req_r) & pay_ack)),
    .expired(expired_s)
  );
`endif

  // Next-state, credit arithmetic and next values of every registered output.
  always_comb begin
    state_s     = state_r;
    credit_s    = credit_r;
    coin_rej_s  = 1'b0;
    pay_acked_s = 1'b0;
    vend_req_s  = 1'b0;
    pay1_req_s  = 1'b0;
    pay2_req_s  = 1'b0;
    busy_s      = 1'b0;

    case (state_r)
      COLLECT: begin
        if (cancel && (credit_r != '0)) begin
          state_s    = PAYOUT;
          coin_rej_s = coin_any_s;
        end else if (coin_any_s) begin
          if (sum_s > MAX_W) begin
            coin_rej_s = 1'b1;
          end else begin
            credit_s   = sum_s[CREDIT_W-1:0];
            coin_rej_s = coin_multi(coin5, coin2, coin1);
            if (sum_s >= PRICE_W) begin
              state_s = VEND;
            end else begin
              state_s = COLLECT;
            end
          end
        end else begin
          state_s = COLLECT;
        end
      end
      VEND: begin
        coin_rej_s = coin_any_s;
        if (vend_req_r && vend_ack) begin
          credit_s = credit_r - PRICE_C;
          if (credit_s == '0) begin
            state_s = COLLECT;
          end else begin
            state_s = PAYOUT;
          end
        end else begin
          state_s = VEND;
        end
      end
      PAYOUT: begin
        coin_rej_s = coin_any_s;
        if ((pay1_req_r || pay2_req_r) && pay_ack) begin
          pay_acked_s = 1'b1;
          credit_s    = credit_r - (pay2_req_r ? PAY2_C : PAY1_C);
          if (credit_s == '0) begin
            state_s = COLLECT;
          end else begin
            state_s = PAYOUT;
          end
        end else begin
          state_s = PAYOUT;
        end
      end
      FAULT: begin
        coin_rej_s = coin_any_s;
        state_s    = FAULT;
      end
      default: begin
        coin_rej_s = coin_any_s;
        state_s    = COLLECT;
      end
    endcase

`ifdef VEND_CTRL_TIMEOUT_EN
    if (expired_s) begin
      state_s     = FAULT;
      credit_s    = credit_r;
      pay_acked_s = 1'b0;
    end else begin
      state_s = state_s;
    end
    fault_s = (state_s == FAULT);
`endif

    vend_req_s = (state_s == VEND);
    // A just-acked pay request stays low for one cycle before the next coin.
    if ((state_s == PAYOUT) && !pay_acked_s) begin
      pay2_req_s = (credit_s >= PAY2_C);
      pay1_req_s = (credit_s <  PAY2_C);
    end else begin
      pay2_req_s = 1'b0;
      pay1_req_s = 1'b0;
    end
    busy_s = (state_s == VEND) || (state_s == PAYOUT);
  end

  // State, credit and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= COLLECT;
      credit_r   <= '0;
      vend_req_r <= 1'b0;
      pay1_req_r <= 1'b0;
      pay2_req_r <= 1'b0;
      coin_rej_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      credit_r   <= credit_s;
      vend_req_r <= vend_req_s;
      pay1_req_r <= pay1_req_s;
      pay2_req_r <= pay2_req_s;
      coin_rej_r <= coin_rej_s;
      busy_r     <= busy_s;
    end
  end

`ifdef VEND_CTRL_TIMEOUT_EN
  // Sticky fault flag; only rst leaves FAULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_s;
    end
  end
  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

  assign vend_req = vend_req_r;
  assign pay1_req = pay1_req_r;
  assign pay2_req = pay2_req_r;
  assign credit   = credit_r;
  assign coin_rej = coin_rej_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of credit, phase and handshakes.
module tb_vend_ctrl;

  localparam int PRICE = 3;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin1 = 1'b0, coin2 = 1'b0, coin5 = 1'b0, cancel = 1'b0;
  logic vend_ack = 1'b0, pay_ack = 1'b0;
  logic vend_req, pay1_req, pay2_req, coin_rej, busy, fault;
  logic [CW-1:0] credit;

  logic o_coin1 = 1'b0, o_coin2 = 1'b0, o_coin5 = 1'b0;
  logic o_vend_req, o_pay1_req, o_pay2_req, o_coin_rej, o_busy, o_fault;
  logic [2:0] o_credit;

  logic [CW+5:0] obs;
  assign obs = {vend_req, pay1_req, pay2_req, coin_rej, busy, fault, credit};

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE(PRICE), .CREDIT_W(CW), .ACK_TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .coin1(coin1), .coin2(coin2), .coin5(coin5), .cancel(cancel),
    .vend_req(vend_req), .vend_ack(vend_ack), .pay1_req(pay1_req), .pay2_req(pay2_req),
    .pay_ack(pay_ack), .credit(credit), .coin_rej(coin_rej), .busy(busy), .fault(fault)
  );

  vend_ctrl #(.PRICE(7), .CREDIT_W(3), .ACK_TIMEOUT(8)) u_ovf (
    .clk(clk), .rst(rst), .coin1(o_coin1), .coin2(o_coin2), .coin5(o_coin5), .cancel(1'b0),
    .vend_req(o_vend_req), .vend_ack(1'b0), .pay1_req(o_pay1_req), .pay2_req(o_pay2_req),
    .pay_ack(1'b0), .credit(o_credit), .coin_rej(o_coin_rej), .busy(o_busy), .fault(o_fault)
  );

  int vecs = 0;
  int errs = 0;

  // Behavioural model: phase 0 = collecting, 1 = vending, 2 = paying change.
  int m_credit, m_phase, m_wait;
  bit m_gap, m_vreq, m_p1, m_p2, m_rej, m_busy;

  function automatic logic [CW+5:0] exp_obs();
    logic [CW-1:0] c;
    c = m_credit[CW-1:0];
    return {m_vreq, m_p1, m_p2, m_rej, m_busy, 1'b0, c};
  endfunction

  task automatic model_reset();
    m_credit = 0; m_phase = 0; m_wait = 0;
    m_gap = 0; m_vreq = 0; m_p1 = 0; m_p2 = 0; m_rej = 0; m_busy = 0;
  endtask

  task automatic model_update(input bit c1, c2, c5, can, va, pa);
    bit any, req_any, took;
    int val, n;
    any = c1 | c2 | c5;
    req_any = m_vreq | m_p1 | m_p2;
    took = 0;
    m_rej = 0;
    n = int'(c1) + int'(c2) + int'(c5);
    val = c5 ? 5 : (c2 ? 2 : 1);
    if (m_phase == 0) begin
      if (can && m_credit > 0) begin
        m_phase = 2; m_gap = 0; m_rej = any;
      end else if (any) begin
        if (m_credit + val > MAXC) m_rej = 1;
        else begin
          m_credit += val;
          m_rej = (n > 1);
          if (m_credit >= PRICE) m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      m_rej = any;
      if (m_vreq && va) begin
        took = 1; m_credit -= PRICE; m_gap = 0;
        m_phase = (m_credit == 0) ? 0 : 2;
      end
    end else begin
      m_rej = any;
      if ((m_p1 || m_p2) && pa) begin
        took = 1; m_credit -= m_p2 ? 2 : 1; m_gap = 1;
        if (m_credit == 0) m_phase = 0;
      end else m_gap = 0;
    end
    m_wait = (req_any && !took) ? m_wait + 1 : 0;
    m_vreq = (m_phase == 1);
    m_p2   = (m_phase == 2) && !m_gap && (m_credit >= 2);
    m_p1   = (m_phase == 2) && !m_gap && (m_credit < 2);
    m_busy = (m_phase != 0);
  endtask

  task automatic step(input bit c1, c2, c5, can, va, pa);
    @(negedge clk);
    coin1 = c1; coin2 = c2; coin5 = c5; cancel = can; vend_ack = va; pay_ack = pa;
    @(posedge clk);
    model_update(c1, c2, c5, can, va, pa);
    #1;
    coin1 = 0; coin2 = 0; coin5 = 0; cancel = 0; vend_ack = 0; pay_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    model_reset();
    vecs++;
    if (obs !== '0) begin
      errs++; $display("FAIL reset: got %h expected %h", obs, '0);
    end
    rst = 0;
    @(negedge clk);
    vecs++;
    if (obs !== exp_obs()) begin
      errs++; $display("FAIL reset_release: got %h expected %h", obs, exp_obs());
    end
  endtask

  task automatic test_exact_price();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      vecs++;
      if (obs !== exp_obs() || credit !== i[CW-1:0]) begin
        errs++; $display("FAIL exact_price_coin%0d: got %h expected %h", i, obs, exp_obs());
      end
    end
    vecs++;
    if (vend_req !== 1'b1) begin
      errs++; $display("FAIL exact_price_vreq: got %b expected 1", vend_req);
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    vecs++;
    if (obs !== exp_obs() || {vend_req, pay1_req, pay2_req, busy, credit} !== '0) begin
      errs++; $display("FAIL exact_price_done: got %h expected %h", obs, exp_obs());
    end
  endtask

  task automatic test_change();
    step(0, 0, 1, 0, 0, 0);
    vecs++;
    if (obs !== exp_obs() || vend_req !== 1'b1 || credit !== 4'd5) begin
      errs++; $display("FAIL change_vend: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 1, 0);
    vecs++;
    if (obs !== exp_obs() || pay2_req !== 1'b1 || pay1_req !== 1'b0 || credit !== 4'd2) begin
      errs++; $display("FAIL change_pay2: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (obs !== exp_obs() || {pay1_req, pay2_req, busy, credit} !== '0) begin
      errs++; $display("FAIL change_done: got %h expected %h", obs, exp_obs());
    end
  endtask

  task automatic test_cancel();
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    vecs++;
    if (obs !== exp_obs() || pay2_req !== 1'b1 || credit !== 4'd2) begin
      errs++; $display("FAIL cancel_refund: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (obs !== exp_obs() || credit !== 4'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL cancel_done: got %h expected %h", obs, exp_obs());
    end
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    vecs++;
    if (obs !== exp_obs() || vend_req !== 1'b1 || credit !== 4'd3) begin
      errs++; $display("FAIL cancel_in_vend: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    vecs++;
    if (obs !== exp_obs() || {pay1_req, pay2_req, credit} !== '0) begin
      errs++; $display("FAIL cancel_no_payout: got %h expected %h", obs, exp_obs());
    end
  endtask

  task automatic test_multi_coin();
    step(1, 0, 1, 0, 0, 0);
    vecs++;
    if (obs !== exp_obs() || credit !== 4'd5 || coin_rej !== 1'b1) begin
      errs++; $display("FAIL multi_coin: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 0, 0);
    vecs++;
    if (obs !== exp_obs() || coin_rej !== 1'b0) begin
      errs++; $display("FAIL multi_coin_pulse: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (obs !== exp_obs() || credit !== 4'd0) begin
      errs++; $display("FAIL multi_coin_drain: got %h expected %h", obs, exp_obs());
    end
  endtask

  task automatic test_busy_reject();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    vecs++;
    if (obs !== exp_obs() || coin_rej !== 1'b1 || credit !== 4'd3 || pay2_req !== 1'b1) begin
      errs++; $display("FAIL payout_coin_rej: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (obs !== exp_obs() || credit !== 4'd1 || {pay1_req, pay2_req} !== 2'b00) begin
      errs++; $display("FAIL payout_gap: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (obs !== exp_obs() || credit !== 4'd1 || pay1_req !== 1'b1) begin
      errs++; $display("FAIL stray_ack: got %h expected %h", obs, exp_obs());
    end
    step(0, 0, 0, 0, 0, 1);
    vecs++;
    if (obs !== exp_obs() || credit !== 4'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL payout_done: got %h expected %h", obs, exp_obs());
    end
  endtask

  task automatic test_overflow();
    logic [4:0] seq_c;
    logic [2:0] exp_cr;
    logic       exp_rj;
    step(0, 0, 0, 0, 0, 0);
    // rows: coin2, coin2, coin5 (overflow), coin1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      o_coin2 = (i < 2); o_coin5 = (i == 2); o_coin1 = (i == 3);
      @(posedge clk);
      #1;
      o_coin1 = 0; o_coin2 = 0; o_coin5 = 0;
      seq_c = {2'b00, o_credit};
      exp_cr = (i == 0) ? 3'd2 : ((i == 3) ? 3'd5 : 3'd4);
      exp_rj = (i == 2);
      vecs++;
      if (o_credit !== exp_cr || o_coin_rej !== exp_rj || o_vend_req !== 1'b0) begin
        errs++; $display("FAIL overflow_%0d: got credit %0d rej %b expected credit %0d rej %b",
                         i, seq_c, o_coin_rej, exp_cr, exp_rj);
      end
    end
  endtask

  task automatic test_random();
    bit c1, c2, c5, can, va, pa;
    for (int i = 0; i < 600; i++) begin
      c1  = ($urandom_range(0, 4) == 0);
      c2  = ($urandom_range(0, 4) == 0);
      c5  = ($urandom_range(0, 5) == 0);
      can = ($urandom_range(0, 9) == 0);
      va  = ($urandom_range(0, 1) == 1) || (m_wait >= 5);
      pa  = ($urandom_range(0, 1) == 1) || (m_wait >= 5);
      step(c1, c2, c5, can, va, pa);
      vecs++;
      if (obs !== exp_obs()) begin
        errs++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_obs());
      end
    end
  endtask

  task automatic test_reset_midvend();
    step(0, 0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1;
    #1;
    vecs++;
    if ({vend_req, pay1_req, pay2_req, busy, credit} !== '0) begin
      errs++; $display("FAIL reset_midvend: got %h expected 0", obs);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

`ifdef VEND_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    step(0, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0, 0, 0);
      vecs++;
      if (fault !== (k == 8) || vend_req !== (k != 8)) begin
        errs++; $display("FAIL timeout_%0d: got fault %b vreq %b", k, fault, vend_req);
      end
    end
    step(1, 0, 0, 0, 1, 0);
    vecs++;
    if (fault !== 1'b1 || coin_rej !== 1'b1 || credit !== 4'd5 || busy !== 1'b0) begin
      errs++; $display("FAIL fault_reject: got %h expected fault 1 rej 1 credit 5", obs);
    end
    rst = 1;
    #1;
    vecs++;
    if (fault !== 1'b0 || credit !== 4'd0) begin
      errs++; $display("FAIL fault_clear: got %h expected 0", obs);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_exact_price();
    test_change();
    test_cancel();
    test_multi_coin();
    test_busy_reject();
    test_overflow();
    test_random();
    test_reset_midvend();
`ifdef VEND_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: got no finish expected finish");
    $fatal(1);
  end

endmodule
